j1_io_uartn: RTL and testbench
==============================

// Module: j1_io_uartn
// PURPOSE
//  Parametrised I/O subsystem between the J1 core's io_rd/io_wr port and NCHAN byte-stream UART channels.
//  Each channel has an RX FIFO (receiver side may not back-pressure), a TX FIFO (valid/ready to transmitter),
//  and sticky overflow flags.
//  Sits in the SoC top, replacing the single unbuffered UART port decode; address map keeps bit-12 data / bit-13 status.
// PARAMETERS
//  NCHAN    2   number of UART channels, 1..4; channel index = mem_addr[2:1] (indices >= NCHAN read 0, writes ignored)
//  RXDEPTH  8   RX FIFO entries per channel, power of 2, 2..128
//  TXDEPTH  4   TX FIFO entries per channel, power of 2, 2..128
// PORTS
//  clk       in   1         system clock, all state on rising edge
//  reset     in   1         asynchronous, active-high reset
//  io_rd     in   1         core I/O read strobe (cycle N)
//  io_wr     in   1         core I/O write strobe (cycle N)
//  mem_addr  in   16        core I/O address, qualified by io_rd|io_wr
//  dout      in   16        core write data, qualified by io_wr
//  io_din    out  16        read data to core, valid cycle N+1, held until next io access
//  rx_strobe in   NCHAN     per channel: byte received this cycle
//  rx_data   in   8*NCHAN   per channel received byte, ch k at [8k+7:8k]
//  tx_valid  out  NCHAN     per channel: TX FIFO non-empty
//  tx_data   out  8*NCHAN   per channel TX FIFO head byte
//  tx_ready  in   NCHAN     per channel: transmitter accepts head this cycle (pop when valid&ready)
// BEHAVIOUR
//  Reset: all FIFOs empty, flags 0, registered io_rd_/io_wr_/addr/data 0; so io_din=0, tx_valid=0, tx_data=0.
//  Access pipeline: cycle N registers {io_rd,io_wr,dout}; addr_ updated only when io_rd|io_wr.
//   io_din in N+1 is combinational from addr_ and current state; side effects commit at end of N+1.
//  Decode (addr_ one-hot bits, results OR'd; several bits set -> all effects):
//   bit12 read: {8'd0, RX head byte}; pop RX at end of N+1. Empty -> 0x0000, no pop, no flag.
//   bit12 write: push dout[7:0] to TX. Full -> byte dropped, tx_ovf set.
//   bit13 read: status = {rx_count[7:0], 4'd0, tx_ovf, rx_ovf, rx_nonempty, tx_notfull}. No side effects.
//   bit14 write: control; dout[0] flush RX, [1] flush TX, [2] clear rx_ovf, [3] clear tx_ovf.
//   bit14 read: 0.
//  RX: rx_strobe in cycle M pushes at end of M; visible to status reads from M+1.
//   Push while full and no pop same cycle -> byte dropped, rx_ovf set, FIFO contents untouched.
//   Push+pop same cycle when full: both happen, count unchanged, no overflow.
//   Push+pop when empty: pop no-op, push lands, count=1.
//  TX: pop when tx_valid & tx_ready. CPU write at N -> tx_valid high from N+2 (if previously empty).
//   Write+pop same cycle when full: accepted, no tx_ovf.
//  Priority same cycle: flush beats push/pop (push in flush cycle is lost, no flag).
//   Overflow set beats clear. Flush does not clear flags.
//  Counts: rx_count width clog2(RXDEPTH)+1, zero-extended to 8; pointers wrap modulo depth.
//  Reset mid-operation: everything returns to reset state immediately; in-flight access discarded.
//  io_wr and io_rd in same cycle: both decoded; read data reflects state before write commit.
// TESTING
//  1 Reset, read 0x2000 ch0 -> io_din=0x0001 next cycle. tx_valid=0.
//  2 rx_strobe ch1 bytes 0x41,0x42; read 0x2002 -> 0x0203. Read 0x1002 twice -> 0x0041, 0x0042.
//    Third read -> 0x0000, status 0x0001.
//  3 RXDEPTH+1 strobes ch0, no reads -> status bit2 set, count=RXDEPTH.
//    Reads return first RXDEPTH bytes in order. Write 0x4000 dout=0x0004 -> bit2 clear.
//  4 tx_ready=0, write 0x1000 with 0x55 x (TXDEPTH+1) -> tx_valid ch0 at N+2, tx_data=0x55, status bit3 set, bit0=0.
//    Raise tx_ready -> exactly TXDEPTH pops.
//  5 Full RX with rx_strobe coinciding with bit12 read pop -> no overflow, count stays RXDEPTH.
//    Flush via 0x4000 dout=1 -> count 0.
//  6 Assert reset mid-TX-drain with 3 bytes queued -> tx_valid=0 same cycle, io_din=0, all status cleared.

Source files
------------

// File: rtl/j1_io_uartn_if.sv
// J1 core I/O bus: strobes, address, write data and returned read data.
interface j1_io_uartn_if;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] mem_addr;
    logic [15:0] dout;
    logic [15:0] io_din;

    modport master (output io_rd, output io_wr, output mem_addr, output dout, input io_din);
    modport slave  (input io_rd, input io_wr, input mem_addr, input dout, output io_din);
endinterface

// File: rtl/j1_io_uartn.sv
// Multi-channel buffered UART I/O block for the J1 core.
// Each channel has an RX FIFO fed by the receiver, a TX FIFO drained by the
// transmitter, and sticky overflow flags. Address bit 12 is data, 13 is status, 14 is control.
module j1_io_uartn #(
    parameter int unsigned NCHAN   = 2,
    parameter int unsigned RXDEPTH = 8,
    parameter int unsigned TXDEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    j1_io_uartn_if.slave       bus,
    input  logic [NCHAN-1:0]   rx_strobe,
    input  logic [8*NCHAN-1:0] rx_data,
    output logic [NCHAN-1:0]   tx_valid,
    output logic [8*NCHAN-1:0] tx_data,
    input  logic [NCHAN-1:0]   tx_ready
);
    localparam int unsigned RXAW = $clog2(RXDEPTH);
    localparam int unsigned RXCW = RXAW + 1;
    localparam int unsigned TXAW = $clog2(TXDEPTH);
    localparam int unsigned TXCW = TXAW + 1;

    logic        rd_q, wr_q;
    logic [15:0] addr_q, dout_q;

    logic [NCHAN-1:0][7:0]  rx_head;
    logic [NCHAN-1:0][15:0] status;
    logic [15:0]            rd_data;

    // Capture the core access; the address only follows real accesses so reads hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            dout_q <= '0;
        end else begin
            rd_q   <= bus.io_rd;
            wr_q   <= bus.io_wr;
            dout_q <= bus.dout;
            if (bus.io_rd | bus.io_wr) begin
                addr_q <= bus.mem_addr;
            end
        end
    end

    for (genvar k = 0; k < NCHAN; k++) begin : g_ch
        logic            sel, ctl;
        logic            rx_empty, rx_full, rx_flush, rx_pop, rx_push, rx_ovf_set;
        logic            tx_empty, tx_full, tx_flush, tx_pop, tx_push, tx_ovf_set;
        logic [RXAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
        logic [RXCW-1:0] rx_cnt_q, rx_cnt_d;
        logic            rx_ovf_q, rx_ovf_d;
        logic [TXAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
        logic [TXCW-1:0] tx_cnt_q, tx_cnt_d;
        logic            tx_ovf_q, tx_ovf_d;
        logic [7:0]      rx_mem_q [RXDEPTH];
        logic [7:0]      tx_mem_q [TXDEPTH];

        assign sel      = (addr_q[2:1] == 2'(k));
        assign ctl      = wr_q & addr_q[14] & sel;
        assign rx_empty = (rx_cnt_q == '0);
        assign rx_full  = (rx_cnt_q == RXCW'(RXDEPTH));
        assign tx_empty = (tx_cnt_q == '0);
        assign tx_full  = (tx_cnt_q == TXCW'(TXDEPTH));

        // Pointer/count/flag next state; flush wins over push and pop, overflow set wins over clear
        always_comb begin
            rx_flush   = ctl & dout_q[0];
            rx_pop     = rd_q & addr_q[12] & sel & ~rx_empty & ~rx_flush;
            rx_push    = rx_strobe[k] & (~rx_full | rx_pop) & ~rx_flush;
            rx_ovf_set = rx_strobe[k] & rx_full & ~rx_pop & ~rx_flush;
            tx_flush   = ctl & dout_q[1];
            tx_pop     = tx_ready[k] & ~tx_empty & ~tx_flush;
            tx_push    = wr_q & addr_q[12] & sel & (~tx_full | tx_pop) & ~tx_flush;
            tx_ovf_set = wr_q & addr_q[12] & sel & tx_full & ~tx_pop & ~tx_flush;
            rx_wp_d    = rx_wp_q;
            rx_rp_d    = rx_rp_q;
            rx_cnt_d   = rx_cnt_q + RXCW'(rx_push) - RXCW'(rx_pop);
            rx_ovf_d   = rx_ovf_q;
            tx_wp_d    = tx_wp_q;
            tx_rp_d    = tx_rp_q;
            tx_cnt_d   = tx_cnt_q + TXCW'(tx_push) - TXCW'(tx_pop);
            tx_ovf_d   = tx_ovf_q;
            if (rx_pop)  rx_rp_d = rx_rp_q + RXAW'(1);
            if (rx_push) rx_wp_d = rx_wp_q + RXAW'(1);
            if (tx_pop)  tx_rp_d = tx_rp_q + TXAW'(1);
            if (tx_push) tx_wp_d = tx_wp_q + TXAW'(1);
            if (rx_flush) begin
                rx_rp_d  = rx_wp_q;
                rx_cnt_d = '0;
            end
            if (tx_flush) begin
                tx_rp_d  = tx_wp_q;
                tx_cnt_d = '0;
            end
            if (ctl & dout_q[2]) rx_ovf_d = 1'b0;
            if (ctl & dout_q[3]) tx_ovf_d = 1'b0;
            if (rx_ovf_set)      rx_ovf_d = 1'b1;
            if (tx_ovf_set)      tx_ovf_d = 1'b1;
        end

        // FIFO control state
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rx_wp_q  <= '0;
                rx_rp_q  <= '0;
                rx_cnt_q <= '0;
                rx_ovf_q <= 1'b0;
                tx_wp_q  <= '0;
                tx_rp_q  <= '0;
                tx_cnt_q <= '0;
                tx_ovf_q <= 1'b0;
            end else begin
                rx_wp_q  <= rx_wp_d;
                rx_rp_q  <= rx_rp_d;
                rx_cnt_q <= rx_cnt_d;
                rx_ovf_q <= rx_ovf_d;
                tx_wp_q  <= tx_wp_d;
                tx_rp_q  <= tx_rp_d;
                tx_cnt_q <= tx_cnt_d;
                tx_ovf_q <= tx_ovf_d;
            end
        end

        // FIFO storage; contents are only observed through the counts so need no reset
        always_ff @(posedge clk) begin
            if (rx_push) rx_mem_q[rx_wp_q] <= rx_data[8*k +: 8];
            if (tx_push) tx_mem_q[tx_wp_q] <= dout_q[7:0];
        end

        assign rx_head[k]         = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
        assign status[k]          = {8'(rx_cnt_q), 4'h0, tx_ovf_q, rx_ovf_q, ~rx_empty, ~tx_full};
        assign tx_valid[k]        = ~tx_empty;
        assign tx_data[8*k +: 8]  = tx_empty ? 8'h00 : tx_mem_q[tx_rp_q];
    end

    // Read data: OR of every selected register for the held address
    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NCHAN; k++) begin
            if (addr_q[2:1] == 2'(k)) begin
                if (addr_q[12]) rd_data = rd_data | {8'h00, rx_head[k]};
                if (addr_q[13]) rd_data = rd_data | status[k];
            end
        end
    end

    assign bus.io_din = rd_data;

    logic unused_bits;
    assign unused_bits = ^{addr_q[15], addr_q[11:3], addr_q[0], dout_q[15:8]};
endmodule

// File: tb/tb_j1_io_uartn.sv
// Randomized and directed bench for j1_io_uartn against a queue-based model.
module tb_j1_io_uartn;
    localparam int NCHAN   = 2;
    localparam int RXDEPTH = 8;
    localparam int TXDEPTH = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [NCHAN-1:0]   rx_strobe, tx_valid, tx_ready;
    logic [8*NCHAN-1:0] rx_data, tx_data;

    j1_io_uartn_if bus();

    j1_io_uartn #(.NCHAN(NCHAN), .RXDEPTH(RXDEPTH), .TXDEPTH(TXDEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .rx_strobe(rx_strobe), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: byte queues, sticky flags and the pending core access
    logic [7:0]  rxq [NCHAN][$];
    logic [7:0]  txq [NCHAN][$];
    logic        m_rxovf [NCHAN];
    logic        m_txovf [NCHAN];
    logic        p_rd, p_wr;
    logic [15:0] p_addr, p_dout;

    logic [15:0] rq;
    logic [7:0]  bytes [RXDEPTH+1];
    int          pops;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCHAN; k++) begin
            rxq[k].delete();
            txq[k].delete();
            m_rxovf[k] = 1'b0;
            m_txovf[k] = 1'b0;
        end
        p_rd = 1'b0; p_wr = 1'b0; p_addr = '0; p_dout = '0;
    endtask

    function automatic logic [15:0] exp_din();
        logic [15:0] r;
        int ch;
        r  = '0;
        ch = int'(p_addr[2:1]);
        if (ch < NCHAN) begin
            if (p_addr[12] && rxq[ch].size() > 0) r = r | {8'h00, rxq[ch][0]};
            if (p_addr[13]) r = r | {8'(rxq[ch].size()), 4'h0, m_txovf[ch], m_rxovf[ch],
                                     rxq[ch].size() != 0, txq[ch].size() < TXDEPTH};
        end
        return r;
    endfunction

    function automatic logic [NCHAN-1:0] exp_txv();
        logic [NCHAN-1:0] r;
        for (int k = 0; k < NCHAN; k++) r[k] = txq[k].size() > 0;
        return r;
    endfunction

    function automatic logic [8*NCHAN-1:0] exp_txd();
        logic [8*NCHAN-1:0] r;
        r = '0;
        for (int k = 0; k < NCHAN; k++) if (txq[k].size() > 0) r[8*k +: 8] = txq[k][0];
        return r;
    endfunction

    // One clock edge of the model, using the inputs held across the edge
    task automatic model_edge();
        bit sel, ctl, rx_pop, rx_set, tx_pop, tx_push, tx_set, rx_full, tx_full;
        if (reset) return;
        for (int k = 0; k < NCHAN; k++) begin
            sel     = (int'(p_addr[2:1]) == k);
            ctl     = p_wr && p_addr[14] && sel;
            rx_full = rxq[k].size() == RXDEPTH;
            tx_full = txq[k].size() == TXDEPTH;
            rx_set  = 1'b0;
            tx_set  = 1'b0;
            if (ctl && p_dout[0]) rxq[k].delete();
            else begin
                rx_pop = p_rd && p_addr[12] && sel && rxq[k].size() > 0;
                if (rx_pop) rxq[k].delete(0);
                if (rx_strobe[k]) begin
                    if (rx_full && !rx_pop) rx_set = 1'b1;
                    else rxq[k].push_back(rx_data[8*k +: 8]);
                end
            end
            if (ctl && p_dout[1]) txq[k].delete();
            else begin
                tx_pop  = tx_ready[k] && txq[k].size() > 0;
                tx_push = p_wr && p_addr[12] && sel;
                if (tx_pop) txq[k].delete(0);
                if (tx_push) begin
                    if (tx_full && !tx_pop) tx_set = 1'b1;
                    else txq[k].push_back(p_dout[7:0]);
                end
            end
            if (rx_set) m_rxovf[k] = 1'b1; else if (ctl && p_dout[2]) m_rxovf[k] = 1'b0;
            if (tx_set) m_txovf[k] = 1'b1; else if (ctl && p_dout[3]) m_txovf[k] = 1'b0;
        end
        p_rd   = bus.io_rd;
        p_wr   = bus.io_wr;
        p_dout = bus.dout;
        if (bus.io_rd || bus.io_wr) p_addr = bus.mem_addr;
    endtask

    task automatic compare_all();
        chk("io_din",   32'(bus.io_din), 32'(exp_din()));
        chk("tx_valid", 32'(tx_valid),   32'(exp_txv()));
        chk("tx_data",  32'(tx_data),    32'(exp_txd()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Single-cycle core access; returns io_din in the following cycle
    task automatic io(input logic rd, input logic wr, input logic [15:0] a,
                      input logic [15:0] d, output logic [15:0] q);
        bus.io_rd = rd; bus.io_wr = wr; bus.mem_addr = a; bus.dout = d;
        tick();
        bus.io_rd = 1'b0; bus.io_wr = 1'b0;
        q = bus.io_din;
    endtask

    initial begin
        reset = 1'b1;
        bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.mem_addr = '0; bus.dout = '0;
        rx_strobe = '0; rx_data = '0; tx_ready = '0;
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_din", 32'(bus.io_din), 32'h0);
        chk("rst_txv", 32'(tx_valid), 32'h0);
        chk("rst_txd", 32'(tx_data), 32'h0);

        // Status after reset
        io(1'b1, 1'b0, 16'h2000, 16'h0, rq);
        chk("t1_status", 32'(rq), 32'h0001);
        chk("t1_txv", 32'(tx_valid), 32'h0);

        // Two bytes on channel 1
        rx_strobe = 2'b10; rx_data = {8'h41, 8'h00}; tick();
        rx_data = {8'h42, 8'h00}; tick();
        rx_strobe = '0;
        io(1'b1, 1'b0, 16'h2002, 16'h0, rq); chk("t2_status2", 32'(rq), 32'h0203);
        io(1'b1, 1'b0, 16'h1002, 16'h0, rq); chk("t2_byte0", 32'(rq), 32'h0041);
        io(1'b1, 1'b0, 16'h1002, 16'h0, rq); chk("t2_byte1", 32'(rq), 32'h0042);
        io(1'b1, 1'b0, 16'h1002, 16'h0, rq); chk("t2_empty", 32'(rq), 32'h0000);
        io(1'b1, 1'b0, 16'h2002, 16'h0, rq); chk("t2_status0", 32'(rq), 32'h0001);

        // RX overflow on channel 0
        for (int i = 0; i <= RXDEPTH; i++) begin
            bytes[i] = 8'($urandom);
            rx_strobe = 2'b01; rx_data = {8'h00, bytes[i]}; tick();
        end
        rx_strobe = '0;
        io(1'b1, 1'b0, 16'h2000, 16'h0, rq); chk("t3_status_ovf", 32'(rq), 32'h0807);
        for (int i = 0; i < RXDEPTH; i++) begin
            io(1'b1, 1'b0, 16'h1000, 16'h0, rq);
            chk("t3_order", 32'(rq), 32'(bytes[i]));
        end
        io(1'b0, 1'b1, 16'h4000, 16'h0004, rq);
        io(1'b1, 1'b0, 16'h2000, 16'h0, rq); chk("t3_ovf_clr", 32'(rq), 32'h0001);

        // TX fill with transmitter stalled, then drain
        tx_ready = '0;
        io(1'b0, 1'b1, 16'h1000, 16'h0055, rq);
        chk("t4_txv_n1", 32'(tx_valid[0]), 32'h0);
        tick();
        chk("t4_txv_n2", 32'(tx_valid[0]), 32'h1);
        chk("t4_txd", 32'(tx_data[7:0]), 32'h55);
        for (int i = 0; i < TXDEPTH; i++) io(1'b0, 1'b1, 16'h1000, 16'h0055, rq);
        io(1'b1, 1'b0, 16'h2000, 16'h0, rq); chk("t4_status", 32'(rq), 32'h0008);
        tx_ready = 2'b11;
        pops = 0;
        for (int i = 0; i < 3 * TXDEPTH; i++) begin
            if (tx_valid[0]) pops++;
            tick();
        end
        tx_ready = '0;
        chk("t4_pops", 32'(pops), 32'(TXDEPTH));
        io(1'b0, 1'b1, 16'h4000, 16'h0008, rq);

        // Full RX with simultaneous push and pop, then flush
        for (int i = 0; i < RXDEPTH; i++) begin
            bytes[i] = 8'($urandom);
            rx_strobe = 2'b01; rx_data = {8'h00, bytes[i]}; tick();
        end
        rx_strobe = '0;
        io(1'b1, 1'b0, 16'h1000, 16'h0, rq); chk("t5_head", 32'(rq), 32'(bytes[0]));
        rx_strobe = 2'b01; rx_data = {8'h00, 8'hA5}; tick();
        rx_strobe = '0;
        io(1'b1, 1'b0, 16'h2000, 16'h0, rq); chk("t5_full_noovf", 32'(rq), 32'h0803);
        io(1'b0, 1'b1, 16'h4000, 16'h0001, rq);
        io(1'b1, 1'b0, 16'h2000, 16'h0, rq); chk("t5_flushed", 32'(rq), 32'h0001);

        // Reset in the middle of a TX drain
        for (int i = 0; i < 4; i++) io(1'b0, 1'b1, 16'h1000, 16'(i + 1), rq);
        io(1'b1, 1'b0, 16'h2000, 16'h0, rq);
        tx_ready = 2'b01; tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6_txv", 32'(tx_valid), 32'h0);
        chk("t6_din", 32'(bus.io_din), 32'h0);
        chk("t6_txd", 32'(tx_data), 32'h0);
        repeat (2) tick();
        reset = 1'b0; tx_ready = '0;
        io(1'b1, 1'b0, 16'h2000, 16'h0, rq); chk("t6_status0", 32'(rq), 32'h0001);
        io(1'b1, 1'b0, 16'h2002, 16'h0, rq); chk("t6_status1", 32'(rq), 32'h0001);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  sp;
            logic [1:0]  ch;
            logic [15:0] d;
            for (int k = 0; k < NCHAN; k++) begin
                rx_strobe[k] = ($urandom_range(0, 99) < 30);
                tx_ready[k]  = ($urandom_range(0, 99) < 40);
            end
            rx_data = 16'($urandom);
            if ($urandom_range(0, 99) < 35) begin
                case ($urandom_range(0, 7))
                    0, 1, 2: sp = 3'b001;
                    3, 4:    sp = 3'b010;
                    5:       sp = 3'b100;
                    6:       sp = 3'b011;
                    default: sp = 3'b111;
                endcase
                ch = 2'($urandom_range(0, 3));
                d  = 16'($urandom);
                if ($urandom_range(0, 9) != 0) d[1:0] = 2'b00;
                case ($urandom_range(0, 4))
                    0, 1:    begin bus.io_rd = 1'b1; bus.io_wr = 1'b0; end
                    2, 3:    begin bus.io_rd = 1'b0; bus.io_wr = 1'b1; end
                    default: begin bus.io_rd = 1'b1; bus.io_wr = 1'b1; end
                endcase
                bus.mem_addr = {1'b0, sp, 9'h000, ch, 1'b0};
                bus.dout     = d;
            end else begin
                bus.io_rd = 1'b0; bus.io_wr = 1'b0;
                bus.mem_addr = 16'($urandom); bus.dout = 16'($urandom);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
